// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-through data cache.
// Pure declarations; no logic, no latency, no flow control.
package dcache_pkg;

    localparam int NUM_LINES  = 16;
    localparam int LINE_BYTES = 64;
    localparam int BEATS      = LINE_BYTES / 8;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int TAG_W      = 64 - OFF_W - IDX_W;
    localparam int BEAT_W     = $clog2(BEATS);

    // funct3 access sizes; bit 2 selects zero extension on loads
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_D  = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;
    localparam logic [2:0] SZ_WU = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL_REQ,
        ST_FILL_DATA,
        ST_WR_REQ,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } bus_req_t;

endpackage

// File: rtl/dcache_align.sv
// Byte-lane steering: load extract with sign/zero extension, store lane shift and strobes.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module dcache_align
    import dcache_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [2:0]  byte_off,
    input  logic [63:0] load_dw,
    input  logic [63:0] store_src,
    output logic [63:0] load_data,
    output logic [63:0] store_data,
    output logic [7:0]  store_strb
);

    logic [2:0]  off_al;
    logic [63:0] lane;
    logic [63:0] src_mask;
    logic [7:0]  strb_base;

    always_comb begin
        off_al    = byte_off;
        strb_base = 8'h01;
        src_mask  = 64'h0000_0000_0000_00FF;
        // low address bits below the access size are dropped, never faulted
        case (size[1:0])
            2'b00: begin
                off_al    = byte_off;
                strb_base = 8'h01;
                src_mask  = 64'h0000_0000_0000_00FF;
            end
            2'b01: begin
                off_al    = {byte_off[2:1], 1'b0};
                strb_base = 8'h03;
                src_mask  = 64'h0000_0000_0000_FFFF;
            end
            2'b10: begin
                off_al    = {byte_off[2], 2'b00};
                strb_base = 8'h0F;
                src_mask  = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                off_al    = 3'b000;
                strb_base = 8'hFF;
                src_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        endcase

        lane      = load_dw >> {off_al, 3'b000};
        load_data = lane;
        case (size)
            SZ_B:    load_data = {{56{lane[7]}}, lane[7:0]};
            SZ_H:    load_data = {{48{lane[15]}}, lane[15:0]};
            SZ_W:    load_data = {{32{lane[31]}}, lane[31:0]};
            SZ_BU:   load_data = {56'b0, lane[7:0]};
            SZ_HU:   load_data = {48'b0, lane[15:0]};
            SZ_WU:   load_data = {32'b0, lane[31:0]};
            default: load_data = lane;
        endcase

        store_data = (store_src & src_mask) << {off_al, 3'b000};
        store_strb = strb_base << off_al;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage.
// Latency: hit done 1 cycle after request; miss done 1 cycle after last fill beat; store done 1 cycle after bus handshake.
// Backpressure: requester holds its request until done; bus_req_* held stable while bus_req_ready is low.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        dc_read_req,
    input  logic        dc_write_req,
    input  logic [63:0] dc_addr,
    input  logic [63:0] dc_wdata,
    input  logic [2:0]  dc_data_size,
    output logic        dc_read_done,
    output logic        dc_write_done,
    output logic [63:0] dc_read_data,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [63:0] bus_req_addr,
    output logic [63:0] bus_req_wdata,
    output logic [7:0]  bus_req_wstrb,
    input  logic        bus_resp_valid,
    input  logic [63:0] bus_resp_data
);

    state_t             state_q, state_d;
    logic [63:0]        req_addr_q;
    logic [63:0]        req_wdata_q;
    logic [2:0]         req_size_q;
    logic               req_rd_q;
    logic [BEAT_W-1:0]  beat_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [63:0]        rdata_q;

    logic [TAG_W-1:0]   tag_q  [NUM_LINES];
    logic [63:0]        data_q [NUM_LINES][BEATS];

    logic [IDX_W-1:0]   lk_idx;
    logic               lk_hit;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [BEAT_W-1:0]  req_beat;
    logic               req_hit;
    logic               accept;
    logic               fill_beat;
    logic               fill_last;
    logic               wr_hs;
    logic [63:0]        ld_ext;
    logic [63:0]        st_dat;
    logic [7:0]         st_strb;
    bus_req_t           bus_req;

    // lookup on the live request in IDLE, on the captured request afterwards
    assign lk_idx   = dc_addr[OFF_W +: IDX_W];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == dc_addr[63 -: TAG_W]);
    assign req_idx  = req_addr_q[OFF_W +: IDX_W];
    assign req_tag  = req_addr_q[63 -: TAG_W];
    assign req_beat = req_addr_q[3 +: BEAT_W];
    assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign fill_beat = (state_q == ST_FILL_DATA) && bus_resp_valid;
    assign fill_last = fill_beat && (beat_q == BEAT_W'(BEATS - 1));
    assign wr_hs     = (state_q == ST_WR_REQ) && bus_req_ready;

    dcache_align u_align (
        .size       (req_size_q),
        .byte_off   (req_addr_q[2:0]),
        .load_dw    (data_q[req_idx][req_beat]),
        .store_src  (req_wdata_q),
        .load_data  (ld_ext),
        .store_data (st_dat),
        .store_strb (st_strb)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dc_read_req) begin
                    accept  = 1'b1;
                    state_d = lk_hit ? ST_RESP : ST_FILL_REQ;
                end else if (dc_write_req) begin
                    accept  = 1'b1;
                    state_d = ST_WR_REQ;
                end
            end
            ST_FILL_REQ:  if (bus_req_ready) state_d = ST_FILL_DATA;
            ST_FILL_DATA: if (fill_last)     state_d = ST_RESP;
            ST_WR_REQ:    if (bus_req_ready) state_d = ST_RESP;
            ST_RESP:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // request fields come only from captured state, so they cannot move during a stall
    always_comb begin
        bus_req = '0;
        if (state_q == ST_FILL_REQ) begin
            bus_req.valid = 1'b1;
            bus_req.addr  = {req_addr_q[63:OFF_W], {OFF_W{1'b0}}};
        end else if (state_q == ST_WR_REQ) begin
            bus_req.valid = 1'b1;
            bus_req.we    = 1'b1;
            bus_req.addr  = {req_addr_q[63:3], 3'b000};
            bus_req.wdata = st_dat;
            bus_req.wstrb = st_strb;
        end
    end

    assign bus_req_valid = bus_req.valid;
    assign bus_req_we    = bus_req.we;
    assign bus_req_addr  = bus_req.addr;
    assign bus_req_wdata = bus_req.wdata;
    assign bus_req_wstrb = bus_req.wstrb;

    assign dc_read_done  = (state_q == ST_RESP) && req_rd_q;
    assign dc_write_done = (state_q == ST_RESP) && !req_rd_q;
    assign dc_read_data  = dc_read_done ? ld_ext : rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_size_q  <= '0;
            req_rd_q    <= 1'b0;
            beat_q      <= '0;
            valid_q     <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_addr_q  <= dc_addr;
                req_wdata_q <= dc_wdata;
                req_size_q  <= dc_data_size;
                req_rd_q    <= dc_read_req;
                // the victim line is dead as soon as its refill starts
                if (dc_read_req && !lk_hit) valid_q[lk_idx] <= 1'b0;
            end
            if (fill_beat) beat_q <= beat_q + 1'b1;
            if (fill_last) valid_q[req_idx] <= 1'b1;
            if (dc_read_done) rdata_q <= ld_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_beat) data_q[req_idx][beat_q] <= bus_resp_data;
        if (fill_last) tag_q[req_idx] <= req_tag;
        if (wr_hs && req_hit) begin
            for (int b = 0; b < 8; b++) begin
                if (st_strb[b]) data_q[req_idx][req_beat][8*b +: 8] <= st_dat[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed plus random bench for dcache_ctrl against a byte-memory and resident-line model.
module tb_dcache_ctrl;

    logic        clk;
    logic        reset;
    logic        dc_read_req;
    logic        dc_write_req;
    logic [63:0] dc_addr;
    logic [63:0] dc_wdata;
    logic [2:0]  dc_data_size;
    logic        dc_read_done;
    logic        dc_write_done;
    logic [63:0] dc_read_data;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_we;
    logic [63:0] bus_req_addr;
    logic [63:0] bus_req_wdata;
    logic [7:0]  bus_req_wstrb;
    logic        bus_resp_valid;
    logic [63:0] bus_resp_data;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [logic [63:0]];
    bit          mv   [16];
    logic [53:0] mtag [16];
    logic [63:0] last_rd;

    dcache_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .dc_read_req    (dc_read_req),
        .dc_write_req   (dc_write_req),
        .dc_addr        (dc_addr),
        .dc_wdata       (dc_wdata),
        .dc_data_size   (dc_data_size),
        .dc_read_done   (dc_read_done),
        .dc_write_done  (dc_write_done),
        .dc_read_data   (dc_read_data),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_req_we     (bus_req_we),
        .bus_req_addr   (bus_req_addr),
        .bus_req_wdata  (bus_req_wdata),
        .bus_req_wstrb  (bus_req_wstrb),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_data  (bus_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // untouched memory holds a deterministic pattern; 0x1000 reads 0x8877665544332211
    function automatic logic [7:0] get_byte(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'((int'(a[2:0]) + 1) * 17) ^ a[10:3] ^ a[20:13];
    endfunction

    function automatic logic [63:0] get_dw(input logic [63:0] a);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = get_byte(a + 64'(i));
        return v;
    endfunction

    function automatic logic [63:0] exp_load(input logic [63:0] a, input logic [2:0] sz);
        int n, off;
        logic [63:0] v;
        n   = 1 << sz[1:0];
        off = int'(a[2:0]) & ~(n - 1);
        v   = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = get_byte({a[63:3], 3'b000} + 64'(off + i));
        if (!sz[2] && n < 8 && v[8*n-1]) begin
            for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_rdone"}, dc_read_done, 0);
        check({tag, "_wdone"}, dc_write_done, 0);
        check({tag, "_rdata"}, dc_read_data, 0);
        check({tag, "_bvld"},  bus_req_valid, 0);
        check({tag, "_bwe"},   bus_req_we, 0);
        check({tag, "_baddr"}, bus_req_addr, 0);
        check({tag, "_bwdat"}, bus_req_wdata, 0);
        check({tag, "_bstrb"}, bus_req_wstrb, 0);
    endtask

    task automatic access(input bit is_wr, input bit both, input logic [63:0] addr,
                          input logic [2:0] size, input logic [63:0] wdata,
                          input int stall, input int rst_beat);
        logic [63:0] line_base, dw_addr, exp_wd, wmask, ev;
        logic [7:0]  exp_strb;
        logic [53:0] tagv;
        int nbytes, off, idx, cyc, first_vld, n_vld, hs_cyc, last_beat_cyc, beats, stall_left;
        bit exp_hit, exp_fill, done_seen, hs_done, aborted;

        nbytes    = 1 << size[1:0];
        off       = int'(addr[2:0]) & ~(nbytes - 1);
        dw_addr   = {addr[63:3], 3'b000};
        line_base = {addr[63:6], 6'b0};
        idx       = int'(addr[9:6]);
        tagv      = addr[63:10];
        exp_hit   = !is_wr && mv[idx] && (mtag[idx] == tagv);
        exp_fill  = !is_wr && !exp_hit;
        exp_strb  = 8'(((1 << nbytes) - 1) << off);
        exp_wd    = '0;
        wmask     = '0;
        for (int i = 0; i < 8; i++) begin
            if (exp_strb[i]) begin
                exp_wd[8*i +: 8] = wdata[8*(i-off) +: 8];
                wmask[8*i +: 8]  = 8'hFF;
            end
        end

        dc_addr = addr; dc_data_size = size; dc_wdata = wdata;
        dc_read_req = !is_wr; dc_write_req = is_wr || both;
        bus_req_ready = 0; bus_resp_valid = 0;
        cyc = 0; first_vld = -1; n_vld = 0; hs_cyc = -100; last_beat_cyc = -100;
        beats = 0; stall_left = stall; done_seen = 0; hs_done = 0; aborted = 0;

        while (!done_seen && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            bus_req_ready  = 0;
            bus_resp_data  = {$urandom, $urandom};
            bus_resp_valid = !exp_fill && ($urandom_range(0, 1) == 1);

            if (rst_beat >= 0 && beats == rst_beat) begin
                reset = 1;
                #1;
                check_quiet("midrst");
                dc_read_req = 0; dc_write_req = 0; bus_resp_valid = 0;
                @(posedge clk);
                #1;
                reset = 0;
                for (int i = 0; i < 16; i++) mv[i] = 0;
                last_rd = '0;
                aborted = 1;
                break;
            end

            if (dc_read_done || dc_write_done) begin
                done_seen = 1;
                check("done_kind", {dc_read_done, dc_write_done}, is_wr ? 2'b01 : 2'b10);
                if (is_wr) begin
                    check("wr_done_cyc", cyc, hs_cyc + 1);
                    check("rd_hold_w", dc_read_data, last_rd);
                end else begin
                    check("rd_done_cyc", cyc, exp_hit ? 1 : last_beat_cyc + 1);
                    ev = exp_load(addr, size);
                    check("rd_data", dc_read_data, ev);
                    last_rd = ev;
                end
                dc_read_req = 0; dc_write_req = 0;
            end

            if (bus_req_valid) begin
                n_vld++;
                if (first_vld < 0) first_vld = cyc;
                check("breq_we", bus_req_we, is_wr);
                check("breq_addr", bus_req_addr, is_wr ? dw_addr : line_base);
                if (is_wr) begin
                    check("breq_strb", bus_req_wstrb, exp_strb);
                    check("breq_wdat", bus_req_wdata & wmask, exp_wd);
                end
                if (!hs_done) begin
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        bus_req_ready = 1;
                        hs_done = 1;
                        hs_cyc = cyc;
                    end
                end
            end

            if (exp_fill && hs_done && cyc > hs_cyc && beats < 8 && $urandom_range(0, 3) != 0) begin
                bus_resp_valid = 1;
                bus_resp_data  = get_dw(line_base + 64'(8 * beats));
                if (beats == 7) last_beat_cyc = cyc;
                beats++;
            end
        end

        bus_resp_valid = 0;
        bus_req_ready  = 0;
        dc_read_req = 0; dc_write_req = 0;
        if (!aborted) begin
            check("done_seen", done_seen, 1);
            check("vld_first", first_vld, exp_hit ? -1 : 1);
            check("vld_cycles", n_vld, exp_hit ? 0 : stall + 1);
            if (exp_fill) begin
                check("fill_beats", beats, 8);
                mv[idx]   = 1;
                mtag[idx] = tagv;
            end
            if (is_wr) begin
                for (int i = 0; i < 8; i++) if (exp_strb[i]) mem[dw_addr + 64'(i)] = exp_wd[8*i +: 8];
            end
            @(posedge clk);
            #1;
            check("done_drop", {dc_read_done, dc_write_done}, 2'b00);
            check("rd_hold", dc_read_data, last_rd);
        end
    endtask

    initial begin
        reset = 1;
        dc_read_req = 0; dc_write_req = 0; dc_addr = 0; dc_wdata = 0; dc_data_size = 0;
        bus_req_ready = 0; bus_resp_valid = 0; bus_resp_data = 0;
        for (int i = 0; i < 16; i++) begin
            mv[i] = 0;
            mtag[i] = '0;
        end
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("rst");
        reset = 0;
        @(posedge clk);
        #1;

        access(0, 0, 64'h1000, 3'b011, 0, 0, -1);
        check("fill_lit", dc_read_data, 64'h8877665544332211);
        access(0, 0, 64'h1000, 3'b011, 0, 0, -1);
        check("hit_lit", dc_read_data, 64'h8877665544332211);
        access(0, 0, 64'h1007, 3'b000, 0, 0, -1);
        check("lb_lit", dc_read_data, 64'hFFFFFFFFFFFFFF88);
        access(0, 0, 64'h1007, 3'b100, 0, 0, -1);
        check("lbu_lit", dc_read_data, 64'h88);
        access(0, 0, 64'h1006, 3'b001, 0, 0, -1);
        check("lh_lit", dc_read_data, 64'hFFFFFFFFFFFF8877);
        access(0, 0, 64'h1004, 3'b010, 0, 0, -1);
        check("lw_lit", dc_read_data, 64'hFFFFFFFF88776655);
        access(0, 0, 64'h1004, 3'b110, 0, 0, -1);
        check("lwu_lit", dc_read_data, 64'h88776655);
        access(0, 0, 64'h1007, 3'b010, 0, 0, -1);

        access(1, 0, 64'h1000, 3'b010, 64'hDEADBEEF, 0, -1);
        access(0, 0, 64'h1000, 3'b011, 0, 0, -1);
        check("sw_hit_lit", dc_read_data, 64'h88776655DEADBEEF);
        access(0, 0, 64'h1000, 3'b111, 0, 0, -1);

        access(1, 0, 64'h2003, 3'b000, 64'h5A, 0, -1);
        access(0, 0, 64'h2000, 3'b011, 0, 0, -1);

        access(0, 0, 64'h1000, 3'b011, 0, 0, -1);
        access(0, 0, 64'h1400, 3'b011, 0, 0, -1);
        access(0, 0, 64'h1000, 3'b011, 0, 0, -1);

        access(0, 0, 64'h1040, 3'b011, 0, 5, -1);
        access(1, 0, 64'h104A, 3'b001, 64'hFFFF_1234_ABCD_9876, 5, -1);
        access(0, 1, 64'h1044, 3'b010, 64'h0BAD_0BAD_0BAD_0BAD, 0, -1);
        access(0, 0, 64'h1048, 3'b011, 0, 0, -1);

        access(0, 0, 64'h1080, 3'b011, 0, 0, 4);
        access(0, 0, 64'h1000, 3'b011, 0, 0, -1);

        for (int n = 0; n < 60; n++) begin
            logic [63:0] a;
            bit wr;
            int sel;
            sel = $urandom_range(0, 4);
            case (sel)
                0:       a = 64'h1000;
                1:       a = 64'h1400;
                2:       a = 64'h2000;
                3:       a = 64'h1040;
                default: a = 64'h5FC0;
            endcase
            a  = a + 64'($urandom_range(0, 63));
            wr = ($urandom_range(0, 2) == 0);
            access(wr, !wr && ($urandom_range(0, 7) == 0), a, 3'($urandom_range(0, 7)),
                   {$urandom, $urandom}, $urandom_range(0, 3), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
